// File: rtl/seq_detect_cfg_fsm.sv
// Runtime-loadable serial bit-sequence detector (1..MAX_LEN bits, optional overlap).
// Define SEQ_DETECT_MATCH_COUNT_EN to build the saturating match counter.
module seq_detect_cfg_fsm #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               valid,
  input  logic               a,
  output logic               armed,
  output logic               detected,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   match_count
);

  typedef enum logic {
    ST_UNCFG = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t             r_state;
  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovl;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_detected;
  logic               r_cfg_err;

  logic               w_len_ok;
  logic               w_load_ok;
  logic               w_shift;
  logic [MAX_LEN-1:0] w_hist_next;
  logic [LEN_W-1:0]   w_fill_inc;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_pat_eq;
  logic               w_hit;

  assign w_len_ok    = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  assign w_load_ok   = cfg_load && w_len_ok;
  assign w_shift     = (r_state == ST_RUN) && valid && !cfg_load;
  assign w_hist_next = {r_hist[MAX_LEN-2:0], a};
  assign w_fill_inc  = (r_fill >= LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : r_fill + LEN_W'(1);

  // Only the low r_len bits of pattern and history take part in the compare.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      w_mask[i] = (LEN_W'(i) < r_len);
    end
  end

  assign w_pat_eq = ((w_hist_next ^ r_pat) & w_mask) == '0;
  assign w_hit    = w_shift && (w_fill_inc >= r_len) && w_pat_eq;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_UNCFG;
      r_pat      <= '0;
      r_len      <= '0;
      r_ovl      <= 1'b0;
      r_hist     <= '0;
      r_fill     <= '0;
      r_detected <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_detected <= 1'b0;
      r_cfg_err  <= 1'b0;
      if (cfg_load) begin
        if (w_len_ok) begin
          r_pat   <= cfg_pattern;
          r_len   <= cfg_len;
          r_ovl   <= cfg_overlap;
          r_hist  <= '0;
          r_fill  <= '0;
          r_state <= ST_RUN;
        end else begin
          r_cfg_err <= 1'b1;
        end
      end else if (w_shift) begin
        r_hist     <= w_hist_next;
        r_detected <= w_hit;
        // Non-overlapping mode forces the next match to start from fresh bits.
        r_fill     <= (w_hit && !r_ovl) ? '0 : w_fill_inc;
      end
    end
  end

  assign armed    = (r_state == ST_RUN);
  assign detected = r_detected;
  assign cfg_err  = r_cfg_err;

`ifdef SEQ_DETECT_MATCH_COUNT_EN
  logic [CNT_W-1:0] r_count;

  // Saturating hit counter, cleared by reset or an accepted reload.
  always_ff @(posedge clk) begin
    if (rst || w_load_ok) begin
      r_count <= '0;
    end else if (w_hit && !(&r_count)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign match_count = r_count;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detect_cfg_fsm.sv
// Directed self-checking bench for seq_detect_cfg_fsm (MAX_LEN=8, CNT_W=2).
module tb_seq_detect_cfg_fsm;

`ifdef SEQ_DETECT_MATCH_COUNT_EN
  localparam bit HAS_CNT = 1'b1;
`else
  localparam bit HAS_CNT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       valid = 1'b0;
  logic       a = 1'b0;
  logic       armed;
  logic       detected;
  logic       cfg_err;
  logic [1:0] match_count;

  int n_checks = 0;
  int n_errors = 0;

  seq_detect_cfg_fsm #(.MAX_LEN(8), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .valid(valid), .a(a),
    .armed(armed), .detected(detected), .cfg_err(cfg_err), .match_count(match_count)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic v, input logic b);
    cfg_load = 1'b0; valid = v; a = b;
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                      input logic v, input logic b);
    cfg_load = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl; valid = v; a = b;
    @(posedge clk); #1;
    cfg_load = 1'b0; valid = 1'b0;
  endtask

  function automatic logic [1:0] exp_cnt(input int k);
    if (!HAS_CNT) return 2'd0;
    return (k > 3) ? 2'd3 : 2'(k);
  endfunction

  task automatic test_reset;
    rst = 1'b1; tick(1'b1, 1'b1); tick(1'b1, 1'b1); rst = 1'b0;
    n_checks++;
    if ({armed, detected, cfg_err, match_count} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset {armed,det,err,cnt}=%b expected 00000", {armed, detected, cfg_err, match_count});
    end
  endtask

  task automatic test_overlap(input logic ovl);
    logic bits [10] = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1};
    logic exp  [10];
    exp = ovl ? '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1} : '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    load(8'b0011_0011, 4'd6, ovl, 1'b0, 1'b0);
    n_checks++;
    if (armed !== 1'b1 || match_count !== 2'd0) begin
      n_errors++;
      $display("FAIL ovl%0d_load armed=%b cnt=%0d expected armed=1 cnt=0", ovl, armed, match_count);
    end
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, bits[i]);
      n_checks++;
      if (detected !== exp[i]) begin
        n_errors++;
        $display("FAIL ovl%0d_bit%0d detected=%b expected=%b", ovl, i + 1, detected, exp[i]);
      end
    end
    n_checks++;
    if (match_count !== exp_cnt(ovl ? 2 : 1)) begin
      n_errors++;
      $display("FAIL ovl%0d_count match_count=%0d expected=%0d", ovl, match_count, exp_cnt(ovl ? 2 : 1));
    end
  endtask

  task automatic test_gaps;
    logic bits [4] = '{1, 0, 1, 0};
    load(8'b0000_1010, 4'd4, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        for (int g = 0; g < 3; g++) begin
          tick(1'b0, 1'b1);
          n_checks++;
          if (detected !== 1'b0) begin
            n_errors++;
            $display("FAIL gap%0d_%0d detected=%b expected=0", i, g, detected);
          end
        end
      end
      tick(1'b1, bits[i]);
      n_checks++;
      if (detected !== (i == 3)) begin
        n_errors++;
        $display("FAIL gaps_bit%0d detected=%b expected=%b", i + 1, detected, (i == 3));
      end
    end
  endtask

  task automatic test_cfg_err;
    rst = 1'b1; tick(1'b0, 1'b0); rst = 1'b0;
    load(8'hFF, 4'd0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (cfg_err !== 1'b1 || armed !== 1'b0) begin
      n_errors++;
      $display("FAIL err_len0 cfg_err=%b armed=%b expected 1 0", cfg_err, armed);
    end
    tick(1'b0, 1'b0);
    n_checks++;
    if (cfg_err !== 1'b0) begin
      n_errors++;
      $display("FAIL err_pulse cfg_err=%b expected=0", cfg_err);
    end
    load(8'hFF, 4'd9, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (cfg_err !== 1'b1 || armed !== 1'b0) begin
      n_errors++;
      $display("FAIL err_len9 cfg_err=%b armed=%b expected 1 0", cfg_err, armed);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1);
      n_checks++;
      if (detected !== 1'b0 || armed !== 1'b0) begin
        n_errors++;
        $display("FAIL err_stream%0d detected=%b armed=%b expected 0 0", i, detected, armed);
      end
    end
    // Illegal reload while running must keep the existing configuration.
    load(8'h01, 4'd1, 1'b1, 1'b0, 1'b0);
    load(8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (cfg_err !== 1'b1 || armed !== 1'b1) begin
      n_errors++;
      $display("FAIL err_running cfg_err=%b armed=%b expected 1 1", cfg_err, armed);
    end
    tick(1'b1, 1'b1);
    n_checks++;
    if (detected !== 1'b1) begin
      n_errors++;
      $display("FAIL err_keep_cfg detected=%b expected=1", detected);
    end
  endtask

  task automatic test_len1_reset;
    load(8'h01, 4'd1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1);
      n_checks++;
      if (detected !== 1'b1) begin
        n_errors++;
        $display("FAIL len1_bit%0d detected=%b expected=1", i + 1, detected);
      end
    end
    rst = 1'b1; tick(1'b1, 1'b1); rst = 1'b0;
    n_checks++;
    if (armed !== 1'b0 || detected !== 1'b0 || match_count !== 2'd0) begin
      n_errors++;
      $display("FAIL midrst armed=%b det=%b cnt=%0d expected 0 0 0", armed, detected, match_count);
    end
  endtask

  task automatic test_len_bounds;
    logic b8 [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    logic b3 [3] = '{1, 0, 1};
    load(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, b8[i]);
      n_checks++;
      if (detected !== (i == 7)) begin
        n_errors++;
        $display("FAIL len8_bit%0d detected=%b expected=%b", i + 1, detected, (i == 7));
      end
    end
    // Upper pattern bits above len are ignored.
    load(8'b1111_0101, 4'd3, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, b3[i]);
      n_checks++;
      if (detected !== (i == 2)) begin
        n_errors++;
        $display("FAIL dontcare_bit%0d detected=%b expected=%b", i + 1, detected, (i == 2));
      end
    end
  endtask

  task automatic test_saturate_reload;
    logic part [5] = '{1, 1, 0, 0, 1};
    load(8'h01, 4'd1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      tick(1'b1, 1'b1);
      n_checks++;
      if (match_count !== exp_cnt(k)) begin
        n_errors++;
        $display("FAIL sat_hit%0d match_count=%0d expected=%0d", k, match_count, exp_cnt(k));
      end
    end
    load(8'b0011_0011, 4'd6, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (match_count !== 2'd0) begin
      n_errors++;
      $display("FAIL reload_clear match_count=%0d expected=0", match_count);
    end
    for (int i = 0; i < 5; i++) tick(1'b1, part[i]);
    load(8'b0011_0011, 4'd6, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1);
    n_checks++;
    if (detected !== 1'b0) begin
      n_errors++;
      $display("FAIL reload_span detected=%b expected=0", detected);
    end
  endtask

  task automatic test_back_to_back;
    load(8'h01, 4'd1, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (detected !== 1'b0) begin
      n_errors++;
      $display("FAIL prio_first detected=%b expected=0", detected);
    end
    load(8'h01, 4'd1, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (detected !== 1'b0) begin
      n_errors++;
      $display("FAIL prio_second detected=%b expected=0", detected);
    end
    tick(1'b1, 1'b1);
    n_checks++;
    if (detected !== 1'b1) begin
      n_errors++;
      $display("FAIL prio_after detected=%b expected=1", detected);
    end
  endtask

  initial begin
    test_reset();
    test_overlap(1'b1);
    test_overlap(1'b0);
    test_gaps();
    test_cfg_err();
    test_len1_reset();
    test_len_bounds();
    test_saturate_reload();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
